// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read data, threshold flags and
// per-request ack/err status. Optional high-water mark: define FIFO_HWM_EN.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
`ifdef FIFO_HWM_EN
    input  logic                  hwm_clr,
    output logic [ADDR_WIDTH:0]   hwm,
`endif
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);
    localparam logic [CW-1:0] AF_LV = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LV = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100,
        WR_RD    = 3'b101,
        WR_RDERR = 3'b110,
        NO_OP    = 3'b111
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count_nxt;
    logic                  do_wr, do_rd;

    assign full         = (data_count == DEPTH);
    assign empty        = (data_count == '0);
    assign almost_full  = (data_count >= AF_LV);
    assign almost_empty = (data_count <= AE_LV);

    always_comb begin
        next_state = NO_OP;
        unique case (1'b1)
            (wr_en && rd_en):  next_state = empty ? WR_RDERR : WR_RD;
            (wr_en && !rd_en): next_state = full ? WR_ERROR : WRITE;
            (!wr_en && rd_en): next_state = empty ? RD_ERROR : READ;
            default:           next_state = NO_OP;
        endcase
    end

    // Actions follow the state being entered, so the edge that decides also acts
    assign do_wr = (next_state == WRITE) || (next_state == WR_RD) ||
                   (next_state == WR_RDERR);
    assign do_rd = (next_state == READ) || (next_state == WR_RD);

    always_comb begin
        count_nxt = data_count;
        if (do_wr && !do_rd)
            count_nxt = data_count + CNT_ONE;
        else if (do_rd && !do_wr)
            count_nxt = data_count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            dout       <= '0;
        end else begin
            state      <= next_state;
            data_count <= count_nxt;
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr];
            end
        end
    end

    // Storage is not reset; when full, WR_RD reads the old word before overwrite
    always_ff @(posedge clk) begin
        if (do_wr && reset_n)
            mem[wr_ptr] <= din;
    end

    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        unique case (state)
            WRITE:    wr_ack = 1'b1;
            READ:     rd_ack = 1'b1;
            WR_RD: begin
                wr_ack = 1'b1;
                rd_ack = 1'b1;
            end
            WR_RDERR: begin
                wr_ack = 1'b1;
                rd_err = 1'b1;
            end
            WR_ERROR: wr_err = 1'b1;
            RD_ERROR: rd_err = 1'b1;
            default: ;
        endcase
    end

`ifdef FIFO_HWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hwm <= '0;
        else if (hwm_clr)
            hwm <= count_nxt;
        else if (count_nxt > hwm)
            hwm <= count_nxt;
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: queue-based reference model checked every
// cycle, plus literal spot checks on the test-plan values.
module tb_fifo_param;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int AF = 6;
    localparam int AE = 1;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [AW:0]   data_count;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_HWM_EN
    logic          hwm_clr = 1'b0;
    logic [AW:0]   hwm;
`endif

    fifo_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .din(din),
`ifdef FIFO_HWM_EN
        .hwm_clr(hwm_clr),
        .hwm(hwm),
`endif
        .dout(dout),
        .data_count(data_count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .rd_ack(rd_ack),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: contents as a queue, status of the last request
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit m_wack, m_werr, m_rack, m_rerr;
    int m_hwm = 0;
    bit chk_on = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        {m_wack, m_werr, m_rack, m_rerr} = '0;
        m_hwm = 0;
    endtask

    // One request cycle; called at a negedge, returns at the next negedge
    task automatic cyc(bit w, bit r, logic [DW-1:0] d, bit clr = 1'b0);
        int n;
        wr_en = w;
        rd_en = r;
        din = d;
`ifdef FIFO_HWM_EN
        hwm_clr = clr;
`endif
        @(posedge clk);
        n = q.size();
        {m_wack, m_werr, m_rack, m_rerr} = '0;
        if (w && r) begin
            if (n == 0) begin
                q.push_back(d);
                m_wack = 1'b1;
                m_rerr = 1'b1;
            end else begin
                m_dout = q.pop_front();
                q.push_back(d);
                m_wack = 1'b1;
                m_rack = 1'b1;
            end
        end else if (w) begin
            if (n == DEPTH) m_werr = 1'b1;
            else begin
                q.push_back(d);
                m_wack = 1'b1;
            end
        end else if (r) begin
            if (n == 0) m_rerr = 1'b1;
            else begin
                m_dout = q.pop_front();
                m_rack = 1'b1;
            end
        end
        if (clr) m_hwm = q.size();
        else if (q.size() > m_hwm) m_hwm = q.size();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifdef FIFO_HWM_EN
        hwm_clr = 1'b0;
`endif
    endtask

    always @(negedge clk) begin
        if (chk_on && reset_n) begin
            chk("count", 64'(data_count), 64'(q.size()));
            chk("full", 64'(full), 64'(q.size() == DEPTH));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            chk("almost_full", 64'(almost_full), 64'(q.size() >= AF));
            chk("almost_empty", 64'(almost_empty), 64'(q.size() <= AE));
            chk("wr_ack", 64'(wr_ack), 64'(m_wack));
            chk("wr_err", 64'(wr_err), 64'(m_werr));
            chk("rd_ack", 64'(rd_ack), 64'(m_rack));
            chk("rd_err", 64'(rd_err), 64'(m_rerr));
            chk("dout", 64'(dout), 64'(m_dout));
`ifdef FIFO_HWM_EN
            chk("hwm", 64'(hwm), 64'(m_hwm));
`endif
        end
    end

    task automatic chk_reset_vals(string tag);
        chk({tag, "_count"}, 64'(data_count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_af"}, 64'(almost_full), 64'd0);
        chk({tag, "_ae"}, 64'(almost_empty), 64'd1);
        chk({tag, "_flags"}, 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'd0);
        chk({tag, "_dout"}, 64'(dout), 64'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        chk_on = 1'b1;

        // 1: fill to full, then one overflow write
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, DW'((i + 1) * 32'h11));
            chk("t1_count", 64'(data_count), 64'(i + 1));
            chk("t1_ae", 64'(almost_empty), 64'(i + 1 <= 1));
            chk("t1_af", 64'(almost_full), 64'(i + 1 >= 6));
        end
        chk("t1_full", 64'(full), 64'd1);
        cyc(1, 0, 32'hDEAD_BEEF);
        chk("t1_wr_err", 64'(wr_err), 64'd1);
        chk("t1_cnt8", 64'(data_count), 64'd8);

        // 2: drain in order, then one underflow read
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, '0);
            chk("t2_dout", 64'(dout), 64'((i + 1) * 32'h11));
            chk("t2_rd_ack", 64'(rd_ack), 64'd1);
        end
        chk("t2_empty", 64'(empty), 64'd1);
        cyc(0, 1, '0);
        chk("t2_rd_err", 64'(rd_err), 64'd1);
        chk("t2_hold", 64'(dout), 64'h88);

        // 3: pointer wrap
        for (int i = 0; i < 5; i++) cyc(1, 0, DW'(32'h30 + i));
        for (int i = 0; i < 5; i++) cyc(0, 1, '0);
        for (int i = 0; i < 8; i++) cyc(1, 0, DW'(32'hA0 + i));
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, '0);
            chk("t3_dout", 64'(dout), 64'(32'hA0 + i));
        end
        chk("t3_count", 64'(data_count), 64'd0);

        // 4: simultaneous read/write at partial, full and empty
        for (int i = 0; i < 3; i++) cyc(1, 0, DW'(32'hB0 + i));
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, DW'(32'hC0 + i));
            chk("t4_both_ack", 64'({wr_ack, rd_ack}), 64'd3);
            chk("t4_cnt3", 64'(data_count), 64'd3);
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, DW'(32'hE0 + i));
        cyc(1, 1, 32'hD0);
        chk("t4_full_noerr", 64'({wr_err, rd_err}), 64'd0);
        chk("t4_full_cnt", 64'(data_count), 64'd8);
        for (int i = 0; i < 8; i++) cyc(0, 1, '0);
        cyc(1, 1, 32'h55);
        chk("t4_rderr", 64'({wr_ack, rd_err}), 64'd3);
        chk("t4_cnt1", 64'(data_count), 64'd1);
        cyc(0, 1, '0);
        chk("t4_dout55", 64'(dout), 64'h55);

        // 5: asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cyc(1, 0, DW'(32'h60 + i));
        chk("t5_cnt5", 64'(data_count), 64'd5);
        wr_en = 1'b1;
        din = 32'hEE;
        #2 reset_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("t5");
        wr_en = 1'b0;
        @(negedge clk);
        chk_reset_vals("t5_hold");
        reset_n = 1'b1;
        cyc(0, 1, '0);
        chk("t5_rd_err", 64'(rd_err), 64'd1);

`ifdef FIFO_HWM_EN
        // 6: high-water mark
        for (int i = 0; i < 7; i++) cyc(1, 0, DW'(i));
        for (int i = 0; i < 4; i++) cyc(0, 1, '0);
        chk("t6_hwm7", 64'(hwm), 64'd7);
        cyc(0, 0, '0, 1'b1);
        chk("t6_hwm3", 64'(hwm), 64'd3);
        cyc(1, 0, 32'h1);
        cyc(1, 0, 32'h2);
        chk("t6_hwm5", 64'(hwm), 64'd5);
`endif

        cyc(0, 0, '0);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
